// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU and its arbiter: the default datapath width and
// the 4-bit op-code encoding used by both the decoder in `alu` and requesters.
// Bit 3 marks the signed group; 4'b0100 is the unsigned subtract/compare.
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] ALU_ADD  = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_OR   = 4'b1011;
    localparam logic [3:0] ALU_SUB  = 4'b1100;
    localparam logic [3:0] ALU_SLL  = 4'b1101;
    localparam logic [3:0] ALU_SRL  = 4'b1110;
    localparam logic [3:0] ALU_SRA  = 4'b1111;
    localparam logic [3:0] ALU_SUBU = 4'b0100;

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two request ports and the shared response bus of alu_arbiter.
//   master : requester side (drives req_*, observes ready and rsp_*)
//   slave  : arbiter side   (observes req_*, drives ready and rsp_*)
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = alu_pkg::DEFAULT_WIDTH
);
    logic             req_valid_0;
    logic             req_valid_1;
    logic             req_ready_0;
    logic             req_ready_1;
    logic [3:0]       req_op_0;
    logic [3:0]       req_op_1;
    logic [WIDTH-1:0] req_a_0;
    logic [WIDTH-1:0] req_b_0;
    logic [WIDTH-1:0] req_a_1;
    logic [WIDTH-1:0] req_b_1;
    logic             rsp_valid_0;
    logic             rsp_valid_1;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_o_flag;
    logic             rsp_z_flag;

    modport master (
        output req_valid_0, req_valid_1, req_op_0, req_op_1,
               req_a_0, req_b_0, req_a_1, req_b_1,
        input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_result, rsp_o_flag, rsp_z_flag
    );

    modport slave (
        input  req_valid_0, req_valid_1, req_op_0, req_op_1,
               req_a_0, req_b_0, req_a_1, req_b_1,
        output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
               rsp_result, rsp_o_flag, rsp_z_flag
    );
endinterface

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational ALU.
//   op     : 4-bit op code (see alu_pkg)
//   a, b   : operands; shifts use the low log2(WIDTH) bits of b as the amount
//   result : operation result (0 for unassigned op codes)
//   o_flag : set-less-than (signed for SUB, unsigned for SUBU, else 0)
//   z_flag : result == 0
// -----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             o_flag,
    output logic             z_flag
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt_s;

    assign shamt_s = b[SHW-1:0];

    // Operation decode; unassigned codes fall through to a zero result.
    always_comb begin
        result = '0;
        o_flag = 1'b0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_AND:  result = a & b;
            ALU_XOR:  result = a ^ b;
            ALU_OR:   result = a | b;
            ALU_SUB: begin
                result = a - b;
                o_flag = ($signed(a) < $signed(b));
            end
            ALU_SLL:  result = a << shamt_s;
            ALU_SRL:  result = a >> shamt_s;
            ALU_SRA:  result = $signed(a) >>> shamt_s;
            ALU_SUBU: begin
                result = a - b;
                o_flag = (a < b);
            end
            default: begin
                result = '0;
                o_flag = 1'b0;
            end
        endcase
    end

    assign z_flag = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between port 0 (execute stage, fixed priority) and port 1
// (auxiliary unit). At most one request is granted per cycle; the granted
// operands drive the ALU combinationally and the result/flags are registered
// back to the granted port one cycle later. A saturating wait counter forces
// a grant to port 1 after STARVE_LIMIT consecutive blocked cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_arbiter_if.slave (requests, combinational ready, rsp_*)
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_arbiter_if.slave bus
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic             gnt_0_s;
    logic             gnt_1_s;
    logic [3:0]       alu_op_s;
    logic [WIDTH-1:0] alu_a_s;
    logic [WIDTH-1:0] alu_b_s;
    logic [WIDTH-1:0] alu_result_s;
    logic             alu_o_s;
    logic             alu_z_s;

    logic [3:0]       wait_cnt_d;
    logic [3:0]       wait_cnt_q;
    logic             rsp_valid_0_d;
    logic             rsp_valid_0_q;
    logic             rsp_valid_1_d;
    logic             rsp_valid_1_q;
    logic [WIDTH-1:0] rsp_result_d;
    logic [WIDTH-1:0] rsp_result_q;
    logic             rsp_o_flag_d;
    logic             rsp_o_flag_q;
    logic             rsp_z_flag_d;
    logic             rsp_z_flag_q;

    // Grant selection: port 0 wins contention unless port 1 has waited the limit.
    always_comb begin
        gnt_0_s = 1'b0;
        gnt_1_s = 1'b0;
        if (bus.req_valid_0 && bus.req_valid_1) begin
            if (wait_cnt_q == LIMIT) begin
                gnt_1_s = 1'b1;
            end else begin
                gnt_0_s = 1'b1;
            end
        end else if (bus.req_valid_0) begin
            gnt_0_s = 1'b1;
        end else if (bus.req_valid_1) begin
            gnt_1_s = 1'b1;
        end else begin
            gnt_0_s = 1'b0;
            gnt_1_s = 1'b0;
        end
    end

    // ALU input mux; idle cycles present all-zero inputs.
    always_comb begin
        alu_op_s = 4'd0;
        alu_a_s  = '0;
        alu_b_s  = '0;
        if (gnt_0_s) begin
            alu_op_s = bus.req_op_0;
            alu_a_s  = bus.req_a_0;
            alu_b_s  = bus.req_b_0;
        end else if (gnt_1_s) begin
            alu_op_s = bus.req_op_1;
            alu_a_s  = bus.req_a_1;
            alu_b_s  = bus.req_b_1;
        end else begin
            alu_op_s = 4'd0;
            alu_a_s  = '0;
            alu_b_s  = '0;
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (alu_op_s),
        .a      (alu_a_s),
        .b      (alu_b_s),
        .result (alu_result_s),
        .o_flag (alu_o_s),
        .z_flag (alu_z_s)
    );

    // Next-state: wait counter saturates rather than wraps; response data holds when idle.
    always_comb begin
        wait_cnt_d    = wait_cnt_q;
        rsp_valid_0_d = gnt_0_s;
        rsp_valid_1_d = gnt_1_s;
        rsp_result_d  = rsp_result_q;
        rsp_o_flag_d  = rsp_o_flag_q;
        rsp_z_flag_d  = rsp_z_flag_q;

        if (!bus.req_valid_1 || gnt_1_s) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < LIMIT) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end

        if (gnt_0_s || gnt_1_s) begin
            rsp_result_d = alu_result_s;
            rsp_o_flag_d = alu_o_s;
            rsp_z_flag_d = alu_z_s;
        end else begin
            rsp_result_d = rsp_result_q;
            rsp_o_flag_d = rsp_o_flag_q;
            rsp_z_flag_d = rsp_z_flag_q;
        end
    end

    // State and response registers; reset drops any grant in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q    <= 4'd0;
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            rsp_result_q  <= '0;
            rsp_o_flag_q  <= 1'b0;
            rsp_z_flag_q  <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            rsp_valid_0_q <= rsp_valid_0_d;
            rsp_valid_1_q <= rsp_valid_1_d;
            rsp_result_q  <= rsp_result_d;
            rsp_o_flag_q  <= rsp_o_flag_d;
            rsp_z_flag_q  <= rsp_z_flag_d;
        end
    end

    assign bus.req_ready_0 = gnt_0_s;
    assign bus.req_ready_1 = gnt_1_s;
    assign bus.rsp_valid_0 = rsp_valid_0_q;
    assign bus.rsp_valid_1 = rsp_valid_1_q;
    assign bus.rsp_result  = rsp_result_q;
    assign bus.rsp_o_flag  = rsp_o_flag_q;
    assign bus.rsp_z_flag  = rsp_z_flag_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed self-checking bench for alu_arbiter (STARVE_LIMIT = 3).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(
        .WIDTH        (W),
        .STARVE_LIMIT (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, summary %0d/%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid_0 = 1'b0;
        bus.req_valid_1 = 1'b0;
        bus.req_op_0    = 4'd0;
        bus.req_op_1    = 4'd0;
        bus.req_a_0     = 32'd0;
        bus.req_b_0     = 32'd0;
        bus.req_a_1     = 32'd0;
        bus.req_b_1     = 32'd0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        total_cnt++; if (bus.rsp_valid_0 !== 1'b0) $display("FAIL rst_rsp_valid_0 got=%b exp=0", bus.rsp_valid_0); else pass_cnt++;
        total_cnt++; if (bus.rsp_valid_1 !== 1'b0) $display("FAIL rst_rsp_valid_1 got=%b exp=0", bus.rsp_valid_1); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd0) $display("FAIL rst_result got=%h exp=0", bus.rsp_result); else pass_cnt++;
        total_cnt++; if ({bus.rsp_o_flag, bus.rsp_z_flag} !== 2'b00) $display("FAIL rst_flags got=%b%b exp=00", bus.rsp_o_flag, bus.rsp_z_flag); else pass_cnt++;
        total_cnt++; if (dut.wait_cnt_q !== 4'd0) $display("FAIL rst_wait_cnt got=%0d exp=0", dut.wait_cnt_q); else pass_cnt++;
        total_cnt++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b00) $display("FAIL rst_ready_idle got=%b%b exp=00", bus.req_ready_0, bus.req_ready_1); else pass_cnt++;
        bus.req_valid_1 = 1'b1;
        #1;
        total_cnt++; if (bus.req_ready_1 !== 1'b1) $display("FAIL rst_ready_follows got=%b exp=1", bus.req_ready_1); else pass_cnt++;
        step();
        total_cnt++; if (bus.rsp_valid_1 !== 1'b0) $display("FAIL rst_no_rsp got=%b exp=0", bus.rsp_valid_1); else pass_cnt++;
        idle();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_port0();
        bus.req_valid_0 = 1'b1; bus.req_op_0 = ALU_ADD; bus.req_a_0 = 32'd5; bus.req_b_0 = 32'd7;
        #1;
        total_cnt++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b10) $display("FAIL p0_ready got=%b%b exp=10", bus.req_ready_0, bus.req_ready_1); else pass_cnt++;
        step();
        idle();
        total_cnt++; if ({bus.rsp_valid_0, bus.rsp_valid_1} !== 2'b10) $display("FAIL p0_rsp_valid got=%b%b exp=10", bus.rsp_valid_0, bus.rsp_valid_1); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd12) $display("FAIL p0_result got=%h exp=%h", bus.rsp_result, 32'd12); else pass_cnt++;
        total_cnt++; if ({bus.rsp_o_flag, bus.rsp_z_flag} !== 2'b00) $display("FAIL p0_flags got=%b%b exp=00", bus.rsp_o_flag, bus.rsp_z_flag); else pass_cnt++;
        #1;
        total_cnt++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b00) $display("FAIL idle_ready got=%b%b exp=00", bus.req_ready_0, bus.req_ready_1); else pass_cnt++;
        step();
        total_cnt++; if ({bus.rsp_valid_0, bus.rsp_valid_1} !== 2'b00) $display("FAIL p0_pulse_end got=%b%b exp=00", bus.rsp_valid_0, bus.rsp_valid_1); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd12) $display("FAIL p0_result_hold got=%h exp=%h", bus.rsp_result, 32'd12); else pass_cnt++;
    endtask

    task automatic test_ops();
        logic [3:0]  op  [12];
        logic [31:0] a   [12];
        logic [31:0] b   [12];
        logic [31:0] res [12];
        logic [1:0]  oz  [12];
        op  = '{ALU_AND, ALU_XOR, ALU_OR, ALU_SLL, ALU_SRL, ALU_SRA,
                ALU_SUB, ALU_SUB, ALU_SUBU, ALU_SUBU, 4'b0011, 4'b0111};
        a   = '{32'hF0F0F0F0, 32'd6, 32'h00001200, 32'd1, 32'h80000000, 32'h80000000,
                32'd3, 32'd9, 32'd5, 32'd3, 32'd5, 32'd1};
        b   = '{32'h0FF00FF0, 32'd3, 32'h00000034, 32'd31, 32'd4, 32'd4,
                32'd5, 32'd9, 32'd3, 32'd5, 32'd3, 32'd1};
        res = '{32'h00F000F0, 32'd5, 32'h00001234, 32'h80000000, 32'h08000000, 32'hF8000000,
                32'hFFFFFFFE, 32'd0, 32'd2, 32'hFFFFFFFE, 32'd0, 32'd0};
        oz  = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b01};
        // Back-to-back port 0 grants: every cycle carries a new op and a pulse.
        for (int i = 0; i < 12; i++) begin
            bus.req_valid_0 = 1'b1; bus.req_op_0 = op[i]; bus.req_a_0 = a[i]; bus.req_b_0 = b[i];
            step();
            total_cnt++; if (bus.rsp_valid_0 !== 1'b1) $display("FAIL ops_valid[%0d] got=%b exp=1", i, bus.rsp_valid_0); else pass_cnt++;
            total_cnt++; if (bus.rsp_result !== res[i]) $display("FAIL ops_result[%0d] got=%h exp=%h", i, bus.rsp_result, res[i]); else pass_cnt++;
            total_cnt++; if ({bus.rsp_o_flag, bus.rsp_z_flag} !== oz[i]) $display("FAIL ops_flags[%0d] got=%b%b exp=%b", i, bus.rsp_o_flag, bus.rsp_z_flag, oz[i]); else pass_cnt++;
        end
        idle();
        step();
    endtask

    task automatic test_port1_back_to_back();
        bus.req_valid_1 = 1'b1; bus.req_op_1 = ALU_SUBU; bus.req_a_1 = 32'd1; bus.req_b_1 = 32'hFFFFFFFF;
        #1;
        total_cnt++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b01) $display("FAIL p1_ready got=%b%b exp=01", bus.req_ready_0, bus.req_ready_1); else pass_cnt++;
        step();
        bus.req_op_1 = ALU_SUB;
        total_cnt++; if ({bus.rsp_valid_0, bus.rsp_valid_1} !== 2'b01) $display("FAIL p1_sltu_valid got=%b%b exp=01", bus.rsp_valid_0, bus.rsp_valid_1); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd2) $display("FAIL p1_sltu_result got=%h exp=2", bus.rsp_result); else pass_cnt++;
        total_cnt++; if ({bus.rsp_o_flag, bus.rsp_z_flag} !== 2'b10) $display("FAIL p1_sltu_flags got=%b%b exp=10", bus.rsp_o_flag, bus.rsp_z_flag); else pass_cnt++;
        step();
        idle();
        total_cnt++; if (bus.rsp_valid_1 !== 1'b1) $display("FAIL p1_slt_valid got=%b exp=1", bus.rsp_valid_1); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd2) $display("FAIL p1_slt_result got=%h exp=2", bus.rsp_result); else pass_cnt++;
        total_cnt++; if ({bus.rsp_o_flag, bus.rsp_z_flag} !== 2'b00) $display("FAIL p1_slt_flags got=%b%b exp=00", bus.rsp_o_flag, bus.rsp_z_flag); else pass_cnt++;
        step();
        total_cnt++; if (bus.rsp_valid_1 !== 1'b0) $display("FAIL p1_pulse_end got=%b exp=0", bus.rsp_valid_1); else pass_cnt++;
    endtask

    task automatic test_starvation();
        logic       exp_g1;
        logic [3:0] exp_wait;
        logic [31:0] exp_res;
        bus.req_valid_1 = 1'b1; bus.req_op_1 = ALU_SUB; bus.req_a_1 = 32'd100; bus.req_b_1 = 32'd1;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid_0 = 1'b1; bus.req_op_0 = ALU_ADD; bus.req_a_0 = 32'(c + 1); bus.req_b_0 = 32'd1;
            exp_g1   = ((c % 4) == 3);
            exp_wait = 4'(c % 4);
            exp_res  = exp_g1 ? 32'd99 : 32'(c + 2);
            #1;
            total_cnt++; if (dut.wait_cnt_q !== exp_wait) $display("FAIL starve_wait[%0d] got=%0d exp=%0d", c, dut.wait_cnt_q, exp_wait); else pass_cnt++;
            total_cnt++; if ({bus.req_ready_0, bus.req_ready_1} !== {~exp_g1, exp_g1}) $display("FAIL starve_grant[%0d] got=%b%b exp=%b%b", c, bus.req_ready_0, bus.req_ready_1, ~exp_g1, exp_g1); else pass_cnt++;
            step();
            total_cnt++; if ({bus.rsp_valid_0, bus.rsp_valid_1} !== {~exp_g1, exp_g1}) $display("FAIL starve_rsp[%0d] got=%b%b exp=%b%b", c, bus.rsp_valid_0, bus.rsp_valid_1, ~exp_g1, exp_g1); else pass_cnt++;
            total_cnt++; if (bus.rsp_result !== exp_res) $display("FAIL starve_result[%0d] got=%h exp=%h", c, bus.rsp_result, exp_res); else pass_cnt++;
        end
        total_cnt++; if (dut.wait_cnt_q !== 4'd0) $display("FAIL starve_clear got=%0d exp=0", dut.wait_cnt_q); else pass_cnt++;
        idle();
        step();
    endtask

    task automatic test_drop();
        bus.req_valid_0 = 1'b1; bus.req_op_0 = ALU_ADD; bus.req_a_0 = 32'd1; bus.req_b_0 = 32'd1;
        bus.req_valid_1 = 1'b1; bus.req_op_1 = ALU_SUB; bus.req_a_1 = 32'd100; bus.req_b_1 = 32'd1;
        step();
        step();
        total_cnt++; if (dut.wait_cnt_q !== 4'd2) $display("FAIL drop_pre_wait got=%0d exp=2", dut.wait_cnt_q); else pass_cnt++;
        bus.req_valid_1 = 1'b0;
        #1;
        total_cnt++; if ({bus.req_ready_0, bus.req_ready_1} !== 2'b10) $display("FAIL drop_grant got=%b%b exp=10", bus.req_ready_0, bus.req_ready_1); else pass_cnt++;
        step();
        total_cnt++; if (dut.wait_cnt_q !== 4'd0) $display("FAIL drop_clear got=%0d exp=0", dut.wait_cnt_q); else pass_cnt++;
        bus.req_valid_1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total_cnt++; if (dut.wait_cnt_q !== 4'(k)) $display("FAIL drop_wait[%0d] got=%0d exp=%0d", k, dut.wait_cnt_q, k); else pass_cnt++;
            total_cnt++; if (bus.req_ready_1 !== (k == 3)) $display("FAIL drop_ready1[%0d] got=%b exp=%b", k, bus.req_ready_1, (k == 3)); else pass_cnt++;
            step();
        end
        total_cnt++; if (bus.rsp_valid_1 !== 1'b1) $display("FAIL drop_rsp1 got=%b exp=1", bus.rsp_valid_1); else pass_cnt++;
        idle();
        step();
    endtask

    task automatic test_reset_mid();
        bus.req_valid_0 = 1'b1; bus.req_op_0 = ALU_ADD; bus.req_a_0 = 32'd2; bus.req_b_0 = 32'd3;
        step();
        total_cnt++; if (bus.rsp_result !== 32'd5) $display("FAIL mid_pre_result got=%h exp=5", bus.rsp_result); else pass_cnt++;
        bus.req_a_0 = 32'd10; bus.req_b_0 = 32'd10;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (bus.rsp_valid_0 !== 1'b0) $display("FAIL mid_async_valid got=%b exp=0", bus.rsp_valid_0); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd0) $display("FAIL mid_async_result got=%h exp=0", bus.rsp_result); else pass_cnt++;
        step();
        total_cnt++; if ({bus.rsp_valid_0, bus.rsp_result} !== {1'b0, 32'd0}) $display("FAIL mid_lost_grant got=%b/%h exp=0/0", bus.rsp_valid_0, bus.rsp_result); else pass_cnt++;
        bus.req_a_0 = 32'd20; bus.req_b_0 = 32'd22;
        rst_n = 1'b1;
        step();
        idle();
        total_cnt++; if (bus.rsp_valid_0 !== 1'b1) $display("FAIL mid_post_valid got=%b exp=1", bus.rsp_valid_0); else pass_cnt++;
        total_cnt++; if (bus.rsp_result !== 32'd42) $display("FAIL mid_post_result got=%h exp=%h", bus.rsp_result, 32'd42); else pass_cnt++;
        step();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        idle();
        test_reset();
        test_port0();
        test_ops();
        test_port1_back_to_back();
        test_starvation();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between two requesters: port 0, the execute stage, and port 1, the auxiliary unit (branch-compare/address-gen). Per cycle it grants at most one request and drives the ALU combinationally with that request's operands. It registers the result and flags back to the granted port one cycle later. Port 0 has fixed priority; a starvation counter guarantees port 1 forward progress.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (passed to `alu`)
- `STARVE_LIMIT`, 4, consecutive blocked cycles after which port 1 wins contention; legal range 1..15

Ports:
- `clk`  in  1  rising-edge clock; the block uses this single clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `req_valid_0`, `req_valid_1`  in  1  request pending on port k
- `req_ready_0`, `req_ready_1`  out  1  grant to port k this cycle; combinational
- `req_op_0`, `req_op_1`  in  4  ALU control code for port k
- `req_a_0`, `req_b_0`, `req_a_1`, `req_b_1`  in  WIDTH  operands for port k
- `rsp_valid_0`, `rsp_valid_1`  out  1  response for port k; one-cycle pulse
- `rsp_result`  out  WIDTH  registered ALU result
- `rsp_o_flag`  out  1  registered set-less-than flag
- `rsp_z_flag`  out  1  registered zero flag

## Operation
- **Handshake.** A transfer occurs on port k when `req_valid_k && req_ready_k` at a rising edge.
  - The requester holds valid, op and operands stable until ready.
  - Valid is never withdrawn before ready.
- **Grant rule**, evaluated combinationally each cycle:
  - Only one port valid: that port is granted.
  - Both ports valid: port 1 is granted iff `wait_cnt == STARVE_LIMIT`; otherwise port 0 is granted.
  - Neither port valid: no grant; the ALU inputs are driven to zero.
- **`wait_cnt`** (width 4), updated at each edge:
  - Increments when port 1 is valid but not granted, saturating at `STARVE_LIMIT`.
  - Clears to 0 when port 1 is granted or `req_valid_1` is 0.
- **Op codes.** Encoding matches `alu`:
  - Bit 3 = signed group: 1000 add, 1001 and, 1010 xor, 1011 or, 1100 sub/slt, 1101 sll, 1110 srl, 1111 sra.
  - 0100 = unsigned sub/sltu.
  - All other codes yield result 0, `z_flag` 1, `o_flag` 0. These codes are still granted and responded to.
- **Response.** On a transfer, the ALU result and flags are captured into `rsp_*` at that edge, and `rsp_valid_k` is set for exactly the following cycle.
  - There is no response backpressure; the consumer must accept.
  - `rsp_result` and flags hold their last value when no response is valid.

## Timing
- **Reset (asynchronous, immediate):**
  - `rsp_valid_0`/`rsp_valid_1` = 0, `rsp_result` = 0, `rsp_o_flag` = 0, `rsp_z_flag` = 0, `wait_cnt` = 0.
  - Ready outputs follow the combinational grant of the current inputs.
- **Latency and throughput:**
  - Grant in cycle N gives a response visible in cycle N+1.
  - Throughput is one operation per cycle; back-to-back grants to the same port produce consecutive `rsp_valid` pulses.
- **Reset mid-operation:** a grant in the cycle reset asserts is lost. No response pulse is produced for it, and the requester must reissue.
- **Simultaneous events:** a response to port k and a new grant to port k in the same cycle are legal.
- **Saturation:** `wait_cnt` does not wrap. At saturation with both ports valid, port 1 wins, and the count clears at that edge.
- **Fairness:** with port 0 continuously valid, port 1 is granted at least once every `STARVE_LIMIT`+1 cycles.

## Structure
- **Shared package `alu_pkg`:**
  - Op-code localparams (`ALU_ADD`, `ALU_AND`, `ALU_XOR`, `ALU_OR`, `ALU_SUB`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_SUBU`).
  - `WIDTH` default.
  - The same constants are used by the decoder.
- **Sub-modules:**
  - One instantiated `alu` sub-module (existing).
  - The grant logic and `wait_cnt` stay inline; there is no separate arbiter sub-module.

## Test plan
- **Single port 0:** add, a=5, b=7 → `req_ready_0`=1 same cycle; next cycle `rsp_valid_0`=1, result 12, z=0, o=0.
- **Single port 1:** sltu, a=1, b=0xFFFFFFFF → result 2, o=1. Then slt with the same operands → o=0 (1 > −1).
- **Zero flag and undefined op:** sub, 9−9 → result 0, z=1. Op 0011 → result 0, z=1, o=0, `rsp_valid` still pulses.
- **Starvation (`STARVE_LIMIT`=3), both ports valid continuously:**
  - Grant pattern is 0,0,0,1 repeating.
  - `wait_cnt` reads 0,1,2,3,0.
  - Each port's `rsp_valid` pulse lands one cycle after its grant.
- **Port 1 drops valid mid-wait:** `wait_cnt` clears. After port 1 reasserts, it needs a full `STARVE_LIMIT` blocked cycles again.
- **Reset mid-operation:**
  - Assert `rst_n`=0 in the cycle after a grant → `rsp_valid` and `rsp_result` clear immediately, without waiting for a clock edge.
  - After release, the first new grant responds normally.
